// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan controller (segment map, blank/off patterns)
package ssd_pkg;
  localparam int MAX_DIGITS = 32;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: combinational hex nibble to active-low a..g segment pattern
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment scanner with PWM and frame-aligned load handshake
// Optional leading-zero blanking when SSD_LZB_EN is defined.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 17,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    load_ack,
  output logic                    frame_tick
);
  import ssd_pkg::*;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic [DIGIT_W-1:0]      presc_q;
  logic [IW-1:0]           idx_q, dig;
  logic [4*NUM_DIGITS-1:0] sh_data_q, pd_data_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blank_q, pd_dp_q, pd_blank_q;
  logic                    pv_q, bnd, commit, lit, lzb;
  logic [3:0]              nib;
  logic [6:0]              dec_seg, seg_d, seg_q;
  logic [NUM_DIGITS-1:0]   anode_d, anode_q;
  logic                    dp_d, dp_q, ack_q, tick_q;
  ssd_hex_decode u_dec (.nib_i(nib), .seg_o(dec_seg));
`ifdef SSD_LZB_EN
  logic [NUM_DIGITS:0] lz;
  assign lz[NUM_DIGITS] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    assign lz[g] = lz[g+1] && sh_data_q[4*g +: 4] == 4'd0;
  end
  assign lzb = lz[dig] && dig != '0;
`else
  assign lzb = 1'b0;
`endif
  // index 0 scans the leftmost digit first
  always_comb begin
    dig = LAST - idx_q;
    bnd = &presc_q && idx_q == LAST;
    commit = bnd && (pv_q || load);
    nib = sh_data_q[4*dig +: 4];
    lit = presc_q[DIGIT_W-1 -: BRIGHT_W] <= brightness && !sh_blank_q[dig];
    anode_d = ANODE_OFF[NUM_DIGITS-1:0];
    anode_d[dig] = !lit;
    seg_d = lit && !lzb ? dec_seg : SEG_BLANK;
    dp_d = lit ? !sh_dp_q[dig] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      pd_data_q  <= '0;
      pd_dp_q    <= '0;
      pd_blank_q <= '0;
      pv_q       <= 1'b0;
      anode_q    <= ANODE_OFF[NUM_DIGITS-1:0];
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) idx_q <= idx_q == LAST ? '0 : idx_q + 1'b1;
      if (load) begin
        pd_data_q  <= data_in;
        pd_dp_q    <= dp_in;
        pd_blank_q <= blank_in;
        pv_q       <= 1'b1;
      end
      if (bnd) pv_q <= 1'b0;
      // a load in the boundary cycle bypasses the pending registers
      if (commit) begin
        sh_data_q  <= load ? data_in  : pd_data_q;
        sh_dp_q    <= load ? dp_in    : pd_dp_q;
        sh_blank_q <= load ? blank_in : pd_blank_q;
      end
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ack_q   <= commit;
      tick_q  <= bnd;
    end
  end
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign load_ack   = ack_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench with a cycle-count reference model of the scanner
module tb_ssd_scan_ctrl;
  localparam int N = 4, DW = 4, BW = 2;
  localparam int SLOT = 1 << DW, FRAME = SLOT * N;
  localparam logic [6:0] HEXMAP [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   sg;
    logic         d, ack, tick;
  } out_t;

  logic clk = 0, rst = 1, load = 0;
  logic [4*N-1:0] data_in = '0;
  logic [N-1:0] dp_in = '0, blank_in = '0;
  logic [BW-1:0] brightness = '1;
  logic [N-1:0] anode;
  logic [6:0] seg;
  logic dp, load_ack, frame_tick;

  out_t q[$];
  int checks = 0, errors = 0;
  int c = 0;
  logic [4*N-1:0] s_data = '0, p_data = '0;
  logic [N-1:0] s_dp = '0, s_bl = '0, p_dp = '0, p_bl = '0;
  bit pv = 0;

  ssd_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_W(DW), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .brightness(brightness), .anode(anode), .seg(seg),
    .dp(dp), .load_ack(load_ack), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Expected outputs after the next edge, from the model's view of the current cycle.
  task automatic step();
    out_t e;
    int p, dig;
    bit b, lit, lzb;
    if (rst) begin
      e.an = '1; e.sg = 7'h7f; e.d = 1; e.ack = 0; e.tick = 0;
      c = 0; s_data = '0; s_dp = '0; s_bl = '0; pv = 0;
    end else begin
      p = c % SLOT;
      dig = N - 1 - (c / SLOT) % N;
      b = (c % FRAME) == FRAME - 1;
      lit = (p >> (DW - BW)) <= int'(brightness) && !s_bl[dig];
      lzb = 0;
`ifdef SSD_LZB_EN
      if (dig != 0) begin
        lzb = 1;
        for (int j = dig; j < N; j++) if (s_data[4*j +: 4] != 0) lzb = 0;
      end
`endif
      e.an = '1;
      if (lit) e.an[dig] = 0;
      e.sg = (lit && !lzb) ? HEXMAP[s_data[4*dig +: 4]] : 7'h7f;
      e.d = lit ? !s_dp[dig] : 1'b1;
      e.ack = b && (pv || load);
      e.tick = b;
      if (load) begin p_data = data_in; p_dp = dp_in; p_bl = blank_in; pv = 1; end
      if (b) begin
        if (pv) begin s_data = p_data; s_dp = p_dp; s_bl = p_bl; end
        pv = 0;
      end
      c++;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] pt, input logic [N-1:0] bl);
    load = 1; data_in = d; dp_in = pt; blank_in = bl;
    step();
    load = 0;
  endtask

  task automatic to_boundary();
    while (c % FRAME != FRAME - 1) step();
  endtask

  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("anode", anode, e.an);
        chk("seg", seg, e.sg);
        chk("dp", dp, e.d);
        chk("load_ack", load_ack, e.ack);
        chk("frame_tick", frame_tick, e.tick);
      end
    end
  end

  initial begin
    rst = 1; run(3);
    rst = 0;
    run(5);
    do_load(16'h12AF, 4'h0, 4'h0);
    run(3 * FRAME);
    brightness = 0; run(FRAME);
    brightness = 2; run(FRAME);
    brightness = 3;
    do_load(16'h1111, 4'h0, 4'h0);
    run(20);
    do_load(16'h2222, 4'h0, 4'h0);
    run(2 * FRAME);
    to_boundary();
    do_load(16'h3C4D, 4'h0, 4'h0);
    run(FRAME);
    do_load(16'h5678, 4'b0001, 4'b0100);
    run(2 * FRAME);
    run(37);
    do_load(16'h9ABC, 4'hF, 4'h0);
    run(10);
    rst = 1; run(2);
    rst = 0; run(2 * FRAME + 10);
    do_load(16'h0050, 4'h0, 4'h0);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0, 4'h0);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0100, 4'h0);
    run(2 * FRAME);
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) begin
        load = 1; data_in = 16'($urandom);
        data_in[15:8] = ($urandom_range(0, 1) == 0) ? 8'h00 : data_in[15:8];
        dp_in = 4'($urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
      rst = $urandom_range(0, 999) == 0;
      step();
      load = 0; rst = 0;
    end
    run(FRAME);
    @(negedge clk); #1;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", c);
    $fatal(1, "timeout");
  end
endmodule
